dot_product_feeder: RTL and testbench

DOT_PRODUCT_FEEDER -- requirements
Module: dot_product_feeder

---
 rtl/dot_product_feeder.sv | 156 +++++++++++++++
 tb/tb_dot_product_feeder.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_feeder.sv
// Operand-pair FIFO feeding a four-element dot-product engine one operation at a time,
// capturing each engine result (or a timeout marker) and holding it for downstream.
module dot_product_feeder #(
    parameter int DATA_WIDTH     = 32,
    parameter int RESULT_WIDTH   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_vec_a,
    input  logic [DATA_WIDTH-1:0]   in_vec_b,
    output logic [DATA_WIDTH-1:0]   mem1_input,
    output logic [DATA_WIDTH-1:0]   mem2_input,
    output logic                    start_processing,
    input  logic [RESULT_WIDTH-1:0] dot_product_result,
    input  logic                    processing_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [RESULT_WIDTH-1:0] res_data,
    output logic                    res_timeout,
    output logic                    busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [DATA_WIDTH-1:0]   mem1_q, mem1_d;
    logic [DATA_WIDTH-1:0]   mem2_q, mem2_d;
    logic                    res_valid_q, res_valid_d;
    logic [RESULT_WIDTH-1:0] res_data_q, res_data_d;
    logic                    res_timeout_q, res_timeout_d;
    logic                    push, pop;

    assign in_ready = (count_q < DEPTH_C);
    assign push     = in_valid && in_ready;
    // The head is taken on the edge leaving IDLE so operands are stable while start is high.
    assign pop      = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {in_vec_a, in_vec_b};
        end
    end

    always_comb begin
        state_d       = state_q;
        tmo_cnt_d     = tmo_cnt_q;
        mem1_d        = mem1_q;
        mem2_d        = mem2_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {mem1_d, mem2_d} = fifo_mem_q[rd_ptr_q];
                    tmo_cnt_d        = '0;
                    state_d          = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle still wins over the timeout.
                if (processing_done) begin
                    res_data_d    = dot_product_result;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = HOLD;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tmo_cnt_q     <= '0;
            mem1_q        <= '0;
            mem2_q        <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mem1_q        <= mem1_d;
            mem2_q        <= mem2_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign mem1_input       = mem1_q;
    assign mem2_input       = mem2_q;
    assign start_processing = (state_q == LAUNCH);
    assign res_valid        = res_valid_q;
    assign res_data         = res_data_q;
    assign res_timeout      = res_timeout_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench for dot_product_feeder: behavioural engine model, scoreboard of expected results
// and launch operands, table-driven vectors plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_dot_product_feeder;

    localparam int DW = 32;
    localparam int RW = 16;
    localparam int FD = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_vec_a = '0;
    logic [DW-1:0] in_vec_b = '0;
    logic [DW-1:0] mem1_input;
    logic [DW-1:0] mem2_input;
    logic          start_processing;
    logic [RW-1:0] dot_product_result;
    logic          processing_done;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [RW-1:0] res_data;
    logic          res_timeout;
    logic          busy;

    always #5 clk = ~clk;

    dot_product_feeder #(
        .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vec_a(in_vec_a), .in_vec_b(in_vec_b),
        .mem1_input(mem1_input), .mem2_input(mem2_input),
        .start_processing(start_processing),
        .dot_product_result(dot_product_result), .processing_done(processing_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_timeout(res_timeout), .busy(busy)
    );

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] exp;
    } vec_t;

    typedef struct packed {
        logic [RW-1:0] d;
        logic          to;
    } res_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    res_t exp_q[$];
    op_t  launch_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int eng_delay = 3;
    bit eng_en    = 1'b1;
    int start_cnt = 0;
    int res_cnt   = 0;
    int last_start_cyc   = 0;
    int last_push_cyc    = 0;
    int last_rv_rise_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] dp(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [RW-1:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s = s + RW'(a[8*i +: 8]) * RW'(b[8*i +: 8]);
        end
        return s;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Engine model: samples operands with the start pulse, answers eng_delay cycles later.
    initial begin
        logic [DW-1:0] ea, eb;
        processing_done    = 1'b0;
        dot_product_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (start_processing && eng_en && rst_n) begin
                ea = mem1_input;
                eb = mem2_input;
                repeat (eng_delay) @(posedge clk);
                #1;
                if (rst_n) begin
                    processing_done    = 1'b1;
                    dot_product_result = dp(ea, eb);
                    @(posedge clk);
                    #1;
                    processing_done    = 1'b0;
                    dot_product_result = 16'hDEAD;
                end
            end
        end
    end

    // Monitor: checks launch operands and delivered results against the scoreboard.
    initial begin
        op_t  op;
        res_t r;
        logic prev_start;
        logic prev_rv;
        prev_start = 1'b0;
        prev_rv    = 1'b0;
        forever begin
            @(negedge clk);
            if (start_processing) begin
                start_cnt++;
                last_start_cyc = cyc;
                chk("start_single_cycle", prev_start, 1'b0);
                if (launch_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL start_unexpected: got start pulse, expected none (cycle %0d)", cyc);
                end else begin
                    op = launch_q.pop_front();
                    chk("mem1_at_start", mem1_input, op.a);
                    chk("mem2_at_start", mem2_input, op.b);
                end
            end
            if (res_valid && !prev_rv) last_rv_rise_cyc = cyc;
            if (res_valid && res_ready) begin
                res_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL result_unexpected: got data 0x%0h, expected no result (cycle %0d)", res_data, cyc);
                end else begin
                    r = exp_q.pop_front();
                    chk("res_data", res_data, r.d);
                    chk("res_timeout", res_timeout, r.to);
                end
            end
            prev_start = start_processing;
            prev_rv    = res_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [RW-1:0] d, input logic to);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        in_vec_a = a;
        in_vec_b = b;
        exp_q.push_back('{d: d, to: to});
        launch_q.push_back('{a: a, b: b});
        @(posedge clk);
        #1;
        last_push_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || launch_q.size() != 0 || busy) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_drained"}, (exp_q.size() == 0 && launch_q.size() == 0 && !busy), 1'b1);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_in_ready"}, in_ready, 1'b1);
        chk({name, "_mem1"}, mem1_input, '0);
        chk({name, "_mem2"}, mem2_input, '0);
        chk({name, "_start"}, start_processing, 1'b0);
        chk({name, "_res_valid"}, res_valid, 1'b0);
        chk({name, "_res_data"}, res_data, '0);
        chk({name, "_res_timeout"}, res_timeout, 1'b0);
        chk({name, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        vec_t tbl[6];
        int   base_start;
        int   base_res;
        int   w;

        tbl[0] = '{a: 32'h01020304, b: 32'h01020304, exp: 16'd30};
        tbl[1] = '{a: 32'h02030405, b: 32'h02030405, exp: 16'd54};
        tbl[2] = '{a: 32'h03040506, b: 32'h03040506, exp: 16'd86};
        tbl[3] = '{a: 32'hFF010203, b: 32'h01FF0000, exp: 16'd510};
        tbl[4] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 16'hF804};
        tbl[5] = '{a: 32'h00000000, b: 32'h12345678, exp: 16'd0};

        #2;
        check_reset("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single operation with latency checks
        eng_delay = 3;
        push(32'h01020304, 32'h01020304, 16'd30, 1'b0);
        drain("single");
        chk("launch_latency", last_start_cyc - last_push_cyc, 1);
        chk("result_latency", last_rv_rise_cyc - last_start_cyc, 4);
        chk("mem1_retained", mem1_input, 32'h01020304);
        chk("mem2_retained", mem2_input, 32'h01020304);
        chk("single_start_count", start_cnt, 1);

        // Table vectors pushed back-to-back
        eng_delay = 2;
        base_start = start_cnt;
        for (int i = 0; i < 6; i++) begin
            push(tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
        end
        drain("table");
        chk("table_start_count", start_cnt - base_start, 6);

        // Done on the expiry cycle wins; done one cycle later is a timeout
        eng_delay = TO;
        push(32'h01010101, 32'h02020202, 16'd8, 1'b0);
        drain("done_at_expiry");
        eng_delay = TO + 1;
        push(32'h01010101, 32'h03030303, 16'd0, 1'b1);
        drain("done_after_expiry");
        repeat (3) @(negedge clk);

        // Engine never answers
        eng_en = 1'b0;
        push(32'h05060708, 32'h05060708, 16'd0, 1'b1);
        drain("timeout");
        chk("timeout_latency", last_rv_rise_cyc - last_start_cyc, TO + 1);

        // Backpressure: stalled engine and consumer, FIFO fills
        res_ready  = 1'b0;
        base_start = start_cnt;
        for (int j = 0; j < 5; j++) begin
            push(32'h01010101 * (j + 1), 32'h01010101, (j == 0) ? 16'd0 : RW'(4 * (j + 1)), (j == 0));
        end
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        chk("full_start_count", start_cnt - base_start, 1);
        in_valid = 1'b1;
        in_vec_a = 32'h06060606;
        in_vec_b = 32'h01010101;
        exp_q.push_back('{d: 16'd24, to: 1'b0});
        launch_q.push_back('{a: 32'h06060606, b: 32'h01010101});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("sixth_blocked", in_ready, 1'b0);
        end
        chk("stall_res_timeout", res_timeout, 1'b1);
        eng_en = 1'b1;
        eng_delay = 3;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("sixth_ready_after_pop", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("backpressure");
        chk("backpressure_start_count", start_cnt - base_start, 6);

        // Result held while consumer stalls; queued pair must not launch
        res_ready = 1'b0;
        base_start = start_cnt;
        push(32'h0A0B0C0D, 32'h0A0B0C0D, 16'd534, 1'b0);
        w = 0;
        while (!res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("hold_res_valid_seen", res_valid, 1'b1);
        push(32'h01020304, 32'h01020304, 16'd30, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_data", res_data, 16'd534);
            chk("hold_res_timeout", res_timeout, 1'b0);
            chk("hold_no_start", start_processing, 1'b0);
        end
        chk("hold_start_count", start_cnt - base_start, 1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        drain("hold");

        // Reset in the middle of WAIT with pairs queued
        eng_en = 1'b0;
        push(32'h11111111, 32'h11111111, 16'd0, 1'b1);
        push(32'h22222222, 32'h22222222, 16'd0, 1'b1);
        push(32'h33333333, 32'h33333333, 16'd0, 1'b1);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset("mid_wait");
        exp_q.delete();
        launch_q.delete();
        base_start = start_cnt;
        base_res   = res_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_no_start", start_cnt - base_start, 0);
        chk("post_reset_no_result", res_cnt - base_res, 0);
        chk("post_reset_res_valid", res_valid, 1'b0);
        chk("post_reset_busy", busy, 1'b0);
        eng_en = 1'b1;
        push(32'h0A0B0C0D, 32'h0A0B0C0D, 16'd534, 1'b0);
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
